i2c_init: RTL and testbench



---
 rtl/i2c_init_pkg.sv | 45 ++++
 rtl/i2c_init.sv | 162 ++++++++++++++++
 tb/tb_i2c_init.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/i2c_init_pkg.sv
// Shared constants for the AK4619 power-on I2C configuration master:
// codec address, the fixed transaction byte ROM and the sequencer state encoding.
package i2c_init_pkg;

    localparam logic [7:0] CODEC_ADDR_W = 8'h20;

    localparam int unsigned ROM_LEN = 10;
    localparam int unsigned IDX_W   = 4;
    localparam int unsigned BIT_W   = 4;

    // Transaction A occupies entries 0..6, transaction B entries 7..9.
    localparam logic [7:0] TXN_ROM [ROM_LEN] = '{
        CODEC_ADDR_W, 8'h00, 8'h36, 8'hAC, 8'h1C, 8'h00, 8'h22,
        CODEC_ADDR_W, 8'h00, 8'h37
    };

    localparam int unsigned TXN_LEN [2] = '{7, 3};

    localparam logic [IDX_W-1:0] LAST_A  = IDX_W'(TXN_LEN[0] - 1);
    localparam logic [IDX_W-1:0] FIRST_B = IDX_W'(TXN_LEN[0]);
    localparam logic [IDX_W-1:0] LAST_B  = IDX_W'(TXN_LEN[0] + TXN_LEN[1] - 1);

    // Index of the acknowledge slot that follows the 8 data bits.
    localparam logic [BIT_W-1:0] ACK_SLOT = BIT_W'(8);

    typedef enum logic [2:0] {
        ST_WAIT,
        ST_START,
        ST_BIT,
        ST_STOP,
        ST_GAP,
        ST_DONE
    } state_t;

    // SDA level for bit slot bit_idx of ROM byte idx: data MSB first, ACK slot released.
    function automatic logic tx_bit(input logic [IDX_W-1:0] idx, input logic [BIT_W-1:0] bit_idx);
        logic [7:0] b;
        b = TXN_ROM[idx];
        if (bit_idx >= ACK_SLOT) begin
            return 1'b1;
        end
        return b[3'(BIT_W'(7) - bit_idx)];
    endfunction

endpackage

// File: rtl/i2c_init.sv
// Power-on I2C write sequencer for the AK4619: waits DELAY clk, sends transactions A and B,
// then parks the bus released. done rises on rising edge DELAY+GAP+376 counted from the
// first edge that samples rst low (edge 1).
module i2c_init
    import i2c_init_pkg::*;
#(
    parameter int unsigned DELAY = 1024,
    parameter int unsigned GAP   = 16
) (
    input  logic clk,
    input  logic rst,
    output logic scl,
    output logic sda_out,
    output logic done
);

    localparam int unsigned CNT_MAX = (DELAY > GAP) ? DELAY : GAP;
    localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);

    state_t             state;
    logic [1:0]         phase;
    logic [CNT_W-1:0]   cnt;
    logic [IDX_W-1:0]   byte_idx;
    logic [BIT_W-1:0]   bit_idx;
    logic               txn_b;
    logic [IDX_W-1:0]   last_idx;

    assign last_idx = txn_b ? LAST_B : LAST_A;

    // phase names the 4-cycle sub-step whose line levels are currently on the outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WAIT;
            phase    <= 2'd0;
            cnt      <= '0;
            byte_idx <= '0;
            bit_idx  <= '0;
            txn_b    <= 1'b0;
            scl      <= 1'b1;
            sda_out  <= 1'b1;
            done     <= 1'b0;
        end else begin
            case (state)
                ST_WAIT: begin
                    if (cnt == CNT_W'(DELAY - 1)) begin
                        state   <= ST_START;
                        phase   <= 2'd0;
                        cnt     <= '0;
                        scl     <= 1'b1;
                        sda_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_START: begin
                    case (phase)
                        2'd0: begin
                            sda_out <= 1'b0;
                            phase   <= 2'd1;
                        end
                        2'd1: phase <= 2'd2;
                        2'd2: begin
                            scl   <= 1'b0;
                            phase <= 2'd3;
                        end
                        default: begin
                            state   <= ST_BIT;
                            phase   <= 2'd0;
                            bit_idx <= '0;
                            sda_out <= tx_bit(byte_idx, BIT_W'(0));
                        end
                    endcase
                end

                // SDA is only updated on the B3->B0 edge, while SCL is low.
                ST_BIT: begin
                    case (phase)
                        2'd0: begin
                            scl   <= 1'b1;
                            phase <= 2'd1;
                        end
                        2'd1: phase <= 2'd2;
                        2'd2: begin
                            scl   <= 1'b0;
                            phase <= 2'd3;
                        end
                        default: begin
                            phase <= 2'd0;
                            if (bit_idx != ACK_SLOT) begin
                                bit_idx <= bit_idx + BIT_W'(1);
                                sda_out <= tx_bit(byte_idx, bit_idx + BIT_W'(1));
                            end else begin
                                bit_idx <= '0;
                                if (byte_idx == last_idx) begin
                                    state   <= ST_STOP;
                                    sda_out <= 1'b0;
                                end else begin
                                    byte_idx <= byte_idx + IDX_W'(1);
                                    sda_out  <= tx_bit(byte_idx + IDX_W'(1), BIT_W'(0));
                                end
                            end
                        end
                    endcase
                end

                ST_STOP: begin
                    case (phase)
                        2'd0: begin
                            scl   <= 1'b1;
                            phase <= 2'd1;
                        end
                        2'd1: begin
                            sda_out <= 1'b1;
                            phase   <= 2'd2;
                        end
                        2'd2: phase <= 2'd3;
                        default: begin
                            phase <= 2'd0;
                            if (!txn_b) begin
                                state    <= ST_GAP;
                                cnt      <= '0;
                                txn_b    <= 1'b1;
                                byte_idx <= FIRST_B;
                            end else begin
                                state <= ST_DONE;
                                done  <= 1'b1;
                            end
                        end
                    endcase
                end

                ST_GAP: begin
                    if (cnt == CNT_W'(GAP - 1)) begin
                        state   <= ST_START;
                        phase   <= 2'd0;
                        cnt     <= '0;
                        scl     <= 1'b1;
                        sda_out <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                ST_DONE: begin
                    scl     <= 1'b1;
                    sda_out <= 1'b1;
                    done    <= 1'b1;
                end

                default: begin
                    state   <= ST_WAIT;
                    phase   <= 2'd0;
                    cnt     <= '0;
                    scl     <= 1'b1;
                    sda_out <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_i2c_init.sv
// Directed bench for i2c_init: decodes the bus from SCL rising edges, tracks START/STOP
// conditions and SCL phase widths, and checks timing, frame contents and mid-frame reset.
module tb_i2c_init;

    localparam int unsigned DELAY    = 4;
    localparam int unsigned GAP      = 2;
    localparam int unsigned DONE_CYC = 382;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic scl;
    logic sda_out;
    logic done;

    int checks = 0;
    int errors = 0;

    logic [7:0] exp_bytes [10] = '{8'h20, 8'h00, 8'h36, 8'hAC, 8'h1C, 8'h00, 8'h22,
                                   8'h20, 8'h00, 8'h37};

    i2c_init #(.DELAY(DELAY), .GAP(GAP)) dut (
        .clk     (clk),
        .rst     (rst),
        .scl     (scl),
        .sda_out (sda_out),
        .done    (done)
    );

    always #5 clk = ~clk;

    // Bus monitor, sampled on the falling edge away from output updates.
    logic       p_scl = 1'b1;
    logic       p_sda = 1'b1;
    logic       hi_valid = 1'b0;
    int         starts = 0;
    int         stops = 0;
    int         bitcnt = 0;
    int         hi_len = 0;
    int         lo_len = 0;
    int         bad_phase = 0;
    logic [7:0] shreg = 8'h00;
    logic [7:0] byte_q [$];
    logic       ack_q [$];

    always @(negedge clk) begin
        if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b1 && sda_out === 1'b0) begin
            starts++;
            bitcnt   = 0;
            hi_valid = 1'b0;
        end else if (p_scl === 1'b1 && scl === 1'b1 && p_sda === 1'b0 && sda_out === 1'b1) begin
            stops++;
            hi_valid = 1'b0;
        end
        if (p_scl === 1'b0 && scl === 1'b1) begin
            if (lo_len < 2) bad_phase++;
            hi_valid = 1'b1;
            hi_len   = 1;
            if (bitcnt < 8) begin
                shreg  = {shreg[6:0], sda_out};
                bitcnt = bitcnt + 1;
            end else begin
                byte_q.push_back(shreg);
                ack_q.push_back(sda_out);
                bitcnt = 0;
            end
        end else if (scl === 1'b1) begin
            hi_len++;
        end
        if (p_scl === 1'b1 && scl === 1'b0) begin
            if (hi_valid && hi_len != 2) bad_phase++;
            lo_len = 1;
        end else if (scl === 1'b0) begin
            lo_len++;
        end
        p_scl = scl;
        p_sda = sda_out;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    initial begin
        int cyc;
        int bad;
        int base;
        int s0;
        logic reached;

        // Reset held for three edges.
        repeat (3) @(posedge clk);
        #1;
        check("reset_lines", 32'({scl, sda_out, done}), 32'b110);
        rst = 1'b0;

        // Released for the first DELAY edges, then run until done.
        bad = 0;
        cyc = 0;
        while (done !== 1'b1 && cyc < int'(DONE_CYC) + 50) begin
            @(posedge clk);
            #1;
            cyc++;
            if (cyc <= int'(DELAY) && {scl, sda_out} !== 2'b11) bad++;
        end
        check("wait_released", 32'(bad), 32'd0);
        check("done_cycle", 32'(cyc), 32'(DONE_CYC));
        check("done_high", 32'(done), 32'd1);

        check("byte_count", 32'(byte_q.size()), 32'd10);
        for (int i = 0; i < 10; i++) begin
            if (i < byte_q.size()) check($sformatf("byte_%0d", i), 32'(byte_q[i]), 32'(exp_bytes[i]));
        end
        bad = 0;
        foreach (ack_q[i]) if (ack_q[i] !== 1'b1) bad++;
        check("ack_released", 32'(bad), 32'd0);
        check("start_count", 32'(starts), 32'd2);
        check("stop_count", 32'(stops), 32'd2);
        check("scl_phase", 32'(bad_phase), 32'd0);

        // Terminal state holds.
        bad = 0;
        repeat (10000) begin
            @(posedge clk);
            #1;
            if ({scl, sda_out, done} !== 3'b111) bad++;
        end
        check("done_hold", 32'(bad), 32'd0);

        // Restart, then reset again in the middle of byte 3 of frame A.
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rerun_reset", 32'({scl, sda_out, done}), 32'b110);
        rst  = 1'b0;
        base = byte_q.size();
        reached = 1'b0;
        for (int i = 0; i < 500 && !reached; i++) begin
            @(posedge clk);
            #1;
            if (byte_q.size() == base + 2 && bitcnt == 4) reached = 1'b1;
        end
        check("mid_reached", 32'(reached), 32'd1);
        check("mid_byte0", 32'(byte_q[base]), 32'h20);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mid_reset_lines", 32'({scl, sda_out, done}), 32'b110);
        rst  = 1'b0;
        base = byte_q.size();
        s0   = starts;

        bad = 0;
        for (int i = 1; i <= int'(DELAY); i++) begin
            @(posedge clk);
            #1;
            if ({scl, sda_out} !== 2'b11) bad++;
        end
        check("mid_wait_released", 32'(bad), 32'd0);
        @(posedge clk);
        #1;
        check("mid_start_edge", 32'({scl, sda_out}), 32'b10);

        for (int i = 0; i < 400 && byte_q.size() < base + 7; i++) begin
            @(posedge clk);
            #1;
        end
        check("mid_byte_count", 32'(byte_q.size() - base), 32'd7);
        for (int i = 0; i < 7; i++) begin
            if (base + i < byte_q.size()) check($sformatf("mid_byte_%0d", i), 32'(byte_q[base + i]), 32'(exp_bytes[i]));
        end
        check("mid_start_count", 32'(starts - s0), 32'd1);
        check("mid_done_low", 32'(done), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
